// File: rtl/fibo_bcd_converter.sv
// fibo_bcd_converter
// Captures a binary result from the Fibonacci calculator and converts it to
// packed BCD with a sequential shift-add-3 (double-dabble) engine. Each step
// handles one input bit. A one-cycle bcd_valid pulse marks a new result.
// Requests that arrive while a conversion is running are dropped, and the
// drop is recorded in the sticky overrun flag.
module fibo_bcd_converter #(
  parameter int BIN_W  = 29,
  parameter int DIGITS = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  bin_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [CNT_W-1:0]   count_q;
  logic [BCD_W-1:0]   bcd_out_q;
  logic               bcd_valid_q;
  logic               overrun_q;

  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W-1:0]   scratch_shifted;
  logic [BIN_W-1:0]   bin_shifted;
  logic               last_step;

  // State register for the conversion FSM.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: idle until a capture, shift until the last bit is in.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; a missing assignment in always_comb would infer a latch.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bin_valid ? SHIFT : IDLE;
      SHIFT:   state_d = last_step ? IDLE : SHIFT;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy for the whole time a conversion is in flight.
  always_comb begin
    busy = (state_q == SHIFT);
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift
  // {scratch, bin} left by one bit.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_shifted = {adjusted[BCD_W-2:0], bin_q[BIN_W-1]};
    bin_shifted     = {bin_q[BIN_W-2:0], 1'b0};
    last_step       = (count_q == CNT_W'(1));
  end

  // Datapath: capture, shift, publish the result, and track dropped requests.
  // NOTE: every register, scratch included, is reset so an aborted
  // conversion leaves nothing behind; there is no memory array to exclude.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q       <= '0;
      scratch_q   <= '0;
      count_q     <= '0;
      bcd_out_q   <= '0;
      bcd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bin_valid) begin
            bin_q     <= bin_in;
            scratch_q <= '0;
            count_q   <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          scratch_q <= scratch_shifted;
          bin_q     <= bin_shifted;
          count_q   <= count_q - CNT_W'(1);
          if (last_step) begin
            bcd_out_q   <= scratch_shifted;
            bcd_valid_q <= 1'b1;
            count_q     <= '0;
          end
          // A request while busy is dropped; remember that it happened.
          if (bin_valid) overrun_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd_out   = bcd_out_q;
  assign bcd_valid = bcd_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fibo_bcd_converter.sv
// Directed bench for fibo_bcd_converter: latency, results, overrun
// handling, reset abort and a sweep over the Fibonacci values 0..31.
module tb_fibo_bcd_converter;

  localparam int BIN_W  = 29;
  localparam int DIGITS = 9;
  localparam int LAT    = 29;

  logic                clk = 1'b0;
  logic                reset;
  logic [BIN_W-1:0]    bin_in;
  logic                bin_valid;
  logic [4*DIGITS-1:0] bcd_out;
  logic                bcd_valid;
  logic                busy;
  logic                overrun;

  int errors = 0;
  int checks = 0;

  fibo_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bin_in    (bin_in),
    .bin_valid (bin_valid),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent decimal-to-BCD reference using division.
  function automatic logic [4*DIGITS-1:0] to_bcd(input longint unsigned v);
    logic [4*DIGITS-1:0] r;
    longint unsigned     t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Drive a one-cycle bin_valid; returns at the first negedge after the capture edge.
  task automatic pulse(input logic [BIN_W-1:0] v);
    @(negedge clk);
    bin_in    = v;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
  endtask

  // Called at the first negedge after a capture; waits for bcd_valid and checks timing and result.
  task automatic wait_done(input logic [4*DIGITS-1:0] exp, input string tag);
    int cyc;
    int busy_cnt;
    cyc      = 0;
    busy_cnt = 0;
    while (!bcd_valid && cyc < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      bin_valid = 1'b0;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(LAT));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    check({tag, " busy_at_valid"}, 64'(busy), 64'd0);
    check({tag, " bcd_out"}, 64'(bcd_out), 64'(exp));
    @(negedge clk);
    check({tag, " valid_one_cycle"}, 64'(bcd_valid), 64'd0);
    check({tag, " hold"}, 64'(bcd_out), 64'(exp));
  endtask

  task automatic run_conv(input logic [BIN_W-1:0] v, input logic [4*DIGITS-1:0] exp, input string tag);
    pulse(v);
    wait_done(exp, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int valid_cnt;
    longint unsigned fa, fb, fn;

    reset     = 1'b1;
    bin_in    = '0;
    bin_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset bcd_out", 64'(bcd_out), 64'd0);
    check("reset bcd_valid", 64'(bcd_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset overrun", 64'(overrun), 64'd0);

    // Basic conversions.
    run_conv(29'd0, 36'h000000000, "zero");
    check("zero overrun", 64'(overrun), 64'd0);
    run_conv(29'd514229, 36'h000514229, "fib29");
    run_conv(29'h1FFFFFFF, 36'h536870911, "max");
    run_conv(29'd10, 36'h000000010, "ten");

    // Overrun: drops at capture+10 and on the final SHIFT edge, accept in valid cycle.
    pulse(29'd832040);                   // k=0
    repeat (9) @(negedge clk);           // k=9
    bin_in = 29'd5; bin_valid = 1'b1;
    @(negedge clk);                      // k=10
    bin_valid = 1'b0;
    check("ovr set", 64'(overrun), 64'd1);
    check("ovr still busy", 64'(busy), 64'd1);
    valid_cnt = 0;
    for (int k = 10; k < 28; k++) begin
      if (bcd_valid) valid_cnt++;
      @(negedge clk);
    end                                  // k=28
    check("ovr no early valid", 64'(valid_cnt), 64'd0);
    bin_in = 29'd5; bin_valid = 1'b1;    // covers the final SHIFT edge and the valid-cycle edge
    @(negedge clk);                      // k=29
    check("ovr valid", 64'(bcd_valid), 64'd1);
    check("ovr result", 64'(bcd_out), 64'h000832040);
    check("ovr sticky", 64'(overrun), 64'd1);
    @(negedge clk);                      // new capture k=0
    bin_valid = 1'b0;
    check("b2b busy", 64'(busy), 64'd1);
    check("b2b no valid", 64'(bcd_valid), 64'd0);
    wait_done(36'h000000005, "b2b");
    check("b2b overrun", 64'(overrun), 64'd1);

    // Reset mid-conversion aborts it and clears overrun.
    pulse(29'd1346269);                  // k=0
    repeat (11) @(negedge clk);          // k=11
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort bcd_out", 64'(bcd_out), 64'd0);
    check("abort overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    valid_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bcd_valid || busy) valid_cnt++;
      @(negedge clk);
    end
    check("abort quiet", 64'(valid_cnt), 64'd0);
    run_conv(29'd89, 36'h000000089, "after_abort");

    // Fibonacci sweep 0..31 with generous spacing.
    do_reset();
    fa = 0;
    fb = 1;
    for (int n = 0; n < 32; n++) begin
      run_conv(BIN_W'(fa), to_bcd(fa), $sformatf("fib%0d", n));
      repeat (4) @(negedge clk);
      fn = fa + fb;
      fa = fb;
      fb = fn;
    end
    check("sweep overrun", 64'(overrun), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
